// File: rtl/banco_registros_wb_pkg.sv
// banco_registros_wb_pkg: shared write-back stage constants
package banco_registros_wb_pkg;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int REG_ZERO    = 0;
endpackage

// File: rtl/banco_registros_wb_mux_wb.sv
// banco_registros_wb_mux_wb: 2:1 write-back select between memory data and ALU result
module banco_registros_wb_mux_wb #(
    parameter int DATA_W = 32
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] en_rd,
    input  logic [DATA_W-1:0] en_alu,
    output logic [DATA_W-1:0] dato_wb
);
    assign dato_wb = sel ? en_rd : en_alu;
endmodule

// File: rtl/banco_registros_wb.sv
// banco_registros_wb: write-back select, 32-entry register bank with bypassed read ports and retired-write counter
module banco_registros_wb
    import banco_registros_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREG   = 2 ** ADDR_W,
    parameter int CNT_W  = 16,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] en_rd,
    input  logic [DATA_W-1:0] en_alu,
    input  logic [ADDR_W-1:0] en_wr,
    input  logic [1:0]        en_wb,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] dato_a,
    output logic [DATA_W-1:0] dato_b,
    output logic [DATA_W-1:0] dato_wb,
    output logic [CNT_W-1:0]  cnt_esc
);
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NREG];
    logic              we_eff;

    banco_registros_wb_mux_wb #(.DATA_W(DATA_W)) u_mux_wb (
        .sel     (en_wb[WB_MEMTOREG]),
        .en_rd   (en_rd),
        .en_alu  (en_alu),
        .dato_wb (dato_wb)
    );

    assign we_eff = en_wb[WB_REGWRITE] && (en_wr != ZERO);

    // register array: cleared asynchronously, written one edge after write-back select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we_eff) begin
            regs[en_wr] <= dato_wb;
        end
    end

    // retired-write counter, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_esc <= '0;
        else if (we_eff && cnt_esc != '1) cnt_esc <= cnt_esc + CNT_W'(1);
    end

    // read ports: register 0 forced to zero, in-flight write forwarded when enabled
    always_comb begin
        dato_a = (rs == ZERO) ? '0 :
                 (BYPASS != 0 && we_eff && rs == en_wr) ? dato_wb : regs[rs];
        dato_b = (rt == ZERO) ? '0 :
                 (BYPASS != 0 && we_eff && rt == en_wr) ? dato_wb : regs[rt];
    end
endmodule

// File: tb/tb_banco_registros_wb.sv
// tb_banco_registros_wb: randomized check of the write-back register bank against a behavioural model
module tb_banco_registros_wb;
    logic        clk = 0, rst_n = 0;
    logic [31:0] en_rd = 0, en_alu = 0;
    logic [4:0]  en_wr = 0, rs = 0, rt = 0;
    logic [1:0]  en_wb = 0;
    logic [31:0] dato_a, dato_b, dato_wb, nb_a, nb_b, nb_wb, st_a, st_b, st_wb;
    logic [15:0] cnt_esc, nb_cnt;
    logic [3:0]  st_cnt;

    logic [31:0] m [32];
    int cnt, cnt4, n_chk, n_fail;

    banco_registros_wb u_dut (.clk(clk), .rst_n(rst_n), .en_rd(en_rd), .en_alu(en_alu), .en_wr(en_wr),
        .en_wb(en_wb), .rs(rs), .rt(rt), .dato_a(dato_a), .dato_b(dato_b), .dato_wb(dato_wb), .cnt_esc(cnt_esc));
    banco_registros_wb #(.BYPASS(0)) u_nb (.clk(clk), .rst_n(rst_n), .en_rd(en_rd), .en_alu(en_alu), .en_wr(en_wr),
        .en_wb(en_wb), .rs(rs), .rt(rt), .dato_a(nb_a), .dato_b(nb_b), .dato_wb(nb_wb), .cnt_esc(nb_cnt));
    banco_registros_wb #(.CNT_W(4)) u_sat (.clk(clk), .rst_n(rst_n), .en_rd(en_rd), .en_alu(en_alu), .en_wr(en_wr),
        .en_wb(en_wb), .rs(rs), .rt(rt), .dato_a(st_a), .dato_b(st_b), .dato_wb(st_wb), .cnt_esc(st_cnt));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] wb_val();
        return en_wb[0] ? en_rd : en_alu;
    endfunction

    function automatic bit writes();
        return en_wb[1] && en_wr != 0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return 0;
        if (byp && writes() && a == en_wr) return wb_val();
        return m[a];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".a"}, dato_a, exp_rd(rs, 1));
        chk({tag, ".b"}, dato_b, exp_rd(rt, 1));
        chk({tag, ".wb"}, dato_wb, wb_val());
        chk({tag, ".cnt"}, {16'h0, cnt_esc}, cnt);
        chk({tag, ".nb_a"}, nb_a, exp_rd(rs, 0));
        chk({tag, ".nb_b"}, nb_b, exp_rd(rt, 0));
        chk({tag, ".cnt4"}, {28'h0, st_cnt}, cnt4);
    endtask

    task automatic step(input string tag, input logic [1:0] wb, input logic [4:0] wr,
                        input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] a, input logic [4:0] b);
        en_wb = wb; en_wr = wr; en_rd = rd; en_alu = alu; rs = a; rt = b;
        #1 check_all(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n && writes()) begin
            m[en_wr] = wb_val();
            if (cnt < 65535) cnt++;
            if (cnt4 < 15) cnt4++;
        end
        @(negedge clk);
    endtask

    task automatic clear_model();
        foreach (m[i]) m[i] = 0;
        cnt = 0;
        cnt4 = 0;
    endtask

    initial begin
        clear_model();
        #1 chk("por.cnt", {16'h0, cnt_esc}, 0);
        @(negedge clk);
        rst_n = 1;
        step("idle", 2'b00, 0, 0, 0, 1, 2);
        step("wr5", 2'b10, 5, 0, 32'hAA, 3, 4); tick();
        step("rd5", 2'b11, 6, 32'hDEADBEEF, 0, 5, 5); tick();
        step("rd6", 2'b00, 0, 0, 0, 6, 5);
        chk("reg6", dato_a, 32'hDEADBEEF);
        chk("cnt2", {16'h0, cnt_esc}, 2);
        step("byp7", 2'b10, 7, 0, 32'h1234, 7, 7);
        chk("byp7.direct", dato_b, 32'h1234);
        chk("nobyp7.direct", nb_a, 0);
        tick();
        step("after7", 2'b00, 0, 0, 0, 7, 7);
        chk("nb7.after", nb_b, 32'h1234);
        step("zero.pre", 2'b11, 0, 32'hFFFFFFFF, 0, 0, 0); tick();
        step("zero.post", 2'b00, 0, 0, 0, 0, 0);
        step("dis", 2'b01, 3, 32'h55, 0, 3, 3); tick();
        step("dis.post", 2'b00, 0, 0, 0, 3, 5);
        // asynchronous reset mid-cycle, no clock edge before the first check
        #2 rst_n = 0;
        #1 clear_model();
        chk("rst.cnt", {16'h0, cnt_esc}, 0);
        chk("rst.reg5", dato_b, 0);
        for (int i = 0; i < 32; i++) begin
            rs = i[4:0]; rt = 5'(31 - i);
            #1 check_all("rst.scan");
        end
        @(negedge clk);
        rst_n = 1;
        step("pre4", 2'b10, 4, 0, 32'h4444, 9, 9); tick();
        // reset coincident with a valid write to reg4
        step("coin", 2'b10, 4, 0, 32'h7777, 4, 9);
        #2 rst_n = 0;
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        step("coin.post", 2'b00, 0, 0, 0, 4, 9);
        chk("reg4.lost", dato_a, 0);
        for (int i = 0; i < 20; i++) begin
            step("sat", 2'b10, 5'(1 + i % 31), 0, 32'(i * 3 + 1), 5'(i), 5'(1 + i % 31)); tick();
        end
        step("sat.end", 2'b00, 0, 0, 0, 1, 2);
        chk("sat15", {28'h0, st_cnt}, 15);
        for (int i = 0; i < 300; i++) begin
            logic [4:0] w;
            w = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            step("rnd", 2'($urandom), w, $urandom, $urandom,
                 ($urandom_range(0, 2) == 0) ? w : 5'($urandom),
                 ($urandom_range(0, 2) == 0) ? w : 5'($urandom));
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/banco_registros_wb.md
Name: banco_registros_wb

Overview:
- Write-back stage plus register bank: the direct consumer of the MEM/WB pipeline buffer outputs (read data, ALU result, destination register, WB control).
- Selects the write-back value and writes it into a 32x32 register file at the clock edge.
- Serves two combinational read ports to the decode stage, with same-cycle write-through bypass so decode never reads a stale value.
- Keeps a saturating count of retired register writes for debug and performance monitoring.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 5, register address width.
- NREG, 32, number of registers (2**ADDR_W).
- CNT_W, 16, width of the retired-write counter.
- BYPASS, 1, 1 = read ports forward the in-flight write; 0 = pure array read.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en_rd  input  DATA_W  memory read data from MEM/WB buffer.
- en_alu  input  DATA_W  ALU result / address from MEM/WB buffer.
- en_wr  input  ADDR_W  destination register from MEM/WB buffer.
- en_wb  input  2  WB control: bit1 = RegWrite, bit0 = MemToReg.
- rs  input  ADDR_W  read address, port A.
- rt  input  ADDR_W  read address, port B.
- dato_a  output  DATA_W  read data, port A.
- dato_b  output  DATA_W  read data, port B.
- dato_wb  output  DATA_W  selected write-back value.
- cnt_esc  output  CNT_W  retired-write counter.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset:
  - rst_n low immediately clears all NREG registers to 0 and cnt_esc to 0, independent of clk.
  - dato_a, dato_b and dato_wb are combinational. During reset they reflect the cleared array and the current inputs.
- Write-back mux (combinational): dato_wb = en_rd when en_wb[0]=1, else en_alu.
- Effective write: we_eff = en_wb[1] & (en_wr != 0).
- Write: on posedge clk with rst_n high and we_eff=1, reg[en_wr] <= dato_wb. Latency is one edge; the value is visible in the array from the next cycle.
- Register 0:
  - Hardwired to 0. Writes to address 0 are discarded.
  - Reads of address 0 return 0 even when a write to 0 is in flight.
- Read ports (combinational, zero latency):
  - dato_a = 0 if rs=0.
  - Else dato_a = dato_wb if BYPASS=1 and we_eff=1 and rs=en_wr.
  - Else dato_a = reg[rs].
  - dato_b follows the same rule with rt.
- Both ports may address the same register, and either may match en_wr; each port resolves independently.
- en_wb[1]=0: no write, no bypass, counter unchanged, regardless of en_wr/en_rd/en_alu.
- Counter:
  - On posedge clk with we_eff=1, cnt_esc increments by 1.
  - Saturates at 2**CNT_W-1 and never wraps.
  - Writes to register 0 do not count.
- Reset mid-operation: a write whose edge coincides with rst_n low is lost. The first write after rst_n rises takes effect on the first rising edge with rst_n high.
- No X-propagation allowed: with en_wb[1]=0, the en_rd/en_alu values must not affect the array.
- Arithmetic: counter is unsigned CNT_W bits. No other arithmetic.

Decomposition:
- Shared pipeline package holds:
  - WB control bit indices: WB_REGWRITE=1, WB_MEMTOREG=0.
  - DATA_W and ADDR_W defaults.
  - The zero-register constant.
- One natural sub-module: mux_wb (2:1 write-back select). The register array, bypass and counter stay in the top module.

Test Plan:
- Reset check: pulse rst_n low mid-cycle -> every rs/rt address reads 0x00000000 and cnt_esc=0 without any clk edge.
- Write/read: en_wb=2'b10, en_wr=5, en_alu=0x0000_00AA, one edge -> reg5 reads 0xAA on both ports, cnt_esc=1. Then en_wb=2'b11, en_wr=6, en_rd=0xDEAD_BEEF -> reg6 reads 0xDEADBEEF, cnt_esc=2.
- Bypass: en_wb=2'b10, en_wr=7, en_alu=0x1234, rs=rt=7 before the edge -> dato_a=dato_b=0x1234 in the same cycle. Repeat with BYPASS=0 -> old value 0 until after the edge.
- Zero register: en_wb=2'b11, en_wr=0, en_rd=0xFFFF_FFFF, rs=0 -> dato_a=0 before and after the edge, cnt_esc unchanged.
- Write disabled: en_wb=2'b01, en_wr=3, en_rd=0x55 -> reg3 unchanged, no bypass on rs=3, cnt_esc unchanged. Then reset asserted coincident with a valid write edge to reg4 -> reg4=0 after reset.
- Saturation: with CNT_W=4, perform 20 effective writes -> cnt_esc stops at 15.
